// File: rtl/pipe_ctrl.sv
// Hazard/freeze controller for a 5-stage pipeline: memory-wait freeze, jump flush, load-use/RAW stall.
// Optional build macro PIPE_CTRL_FORWARD_EN enables operand forwarding selects.

module pipe_ctrl_opnd (
    input  logic [4:0] rs,
    input  logic [4:0] ex_w,
    input  logic [4:0] mem_w,
    input  logic [4:0] wb_w,
    input  logic       ex_is_load,
    output logic       stall_hit,
    output logic [1:0] fwd_sel
);
    logic hit_ex, hit_mem, hit_wb;

    // rs==0 also covers a zero destination, so x0 never matches
    assign hit_ex  = (rs != 5'd0) && (rs == ex_w);
    assign hit_mem = (rs != 5'd0) && (rs == mem_w);
    assign hit_wb  = (rs != 5'd0) && (rs == wb_w);

`ifdef PIPE_CTRL_FORWARD_EN
    assign stall_hit = hit_ex && ex_is_load;
    always_comb begin
        fwd_sel = 2'b00;
        if (hit_ex && !ex_is_load) fwd_sel = 2'b01;
        else if (hit_mem)          fwd_sel = 2'b10;
        else if (hit_wb)           fwd_sel = 2'b11;
    end
`else
    logic unused_load;
    assign unused_load = ex_is_load;
    assign stall_hit   = hit_ex || hit_mem || hit_wb;
    assign fwd_sel     = 2'b00;
`endif
endmodule

module pipe_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic [4:0] ex_w_reg_addr_i,
    input  logic [4:0] mem_w_reg_addr_i,
    input  logic [4:0] wb_w_reg_addr_i,
    input  logic       ex_is_load_i,
    input  logic       mem_busy_i,
    input  logic       ex_jump_i,
    output logic       stall_pc_o,
    output logic       stall_if_id_o,
    output logic       stall_id_ex_o,
    output logic       stall_ex_mem_o,
    output logic       flush_if_id_o,
    output logic       flush_id_ex_o,
    output logic [1:0] fwd_1_sel_o,
    output logic [1:0] fwd_2_sel_o,
    output logic       halt_o,
    output logic [1:0] state_o
);
    typedef enum logic [1:0] {RUN = 2'b00, FREEZE = 2'b01, HALT = 2'b10} state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       jump_pend_q, jump_pend_d;

    logic [1:0][4:0] rs;
    logic [1:0]      stall_hit;
    logic [1:0][1:0] fwd_sel;
    logic            hazard;

    assign rs = {id_rs2_i, id_rs1_i};

    for (genvar g = 0; g < 2; g++) begin : g_opnd
        pipe_ctrl_opnd u_opnd (
            .rs         (rs[g]),
            .ex_w       (ex_w_reg_addr_i),
            .mem_w      (mem_w_reg_addr_i),
            .wb_w       (wb_w_reg_addr_i),
            .ex_is_load (ex_is_load_i),
            .stall_hit  (stall_hit[g]),
            .fwd_sel    (fwd_sel[g])
        );
    end

    assign hazard = id_valid_i && (|stall_hit);

    logic s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, halt;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        jump_pend_d = jump_pend_q;
        s_pc = 1'b0; s_ifid = 1'b0; s_idex = 1'b0; s_exmem = 1'b0;
        f_ifid = 1'b0; f_idex = 1'b0; halt = 1'b0;
        case (state_q)
            RUN, FREEZE: begin
                if (mem_busy_i) begin
                    s_pc = 1'b1; s_ifid = 1'b1; s_idex = 1'b1; s_exmem = 1'b1;
                    jump_pend_d = jump_pend_q | ex_jump_i;
                    if (state_q == RUN) begin
                        state_d    = FREEZE;
                        wait_cnt_d = 8'd1;
                    end else if (wait_cnt_q == 8'hFF) begin
                        state_d = HALT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    state_d     = RUN;
                    wait_cnt_d  = 8'd0;
                    jump_pend_d = 1'b0;
                    // a deferred jump takes effect in the first non-busy cycle
                    if (ex_jump_i || jump_pend_q) begin
                        f_ifid = 1'b1; f_idex = 1'b1;
                    end else if (hazard) begin
                        s_pc = 1'b1; s_ifid = 1'b1; f_idex = 1'b1;
                    end
                end
            end
            HALT: begin
                s_pc = 1'b1; s_ifid = 1'b1; s_idex = 1'b1; s_exmem = 1'b1;
                halt = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            jump_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            jump_pend_q <= jump_pend_d;
        end
    end

    // outputs are forced quiet while reset is held, whatever the inputs
    assign stall_pc_o     = rst_n & s_pc;
    assign stall_if_id_o  = rst_n & s_ifid;
    assign stall_id_ex_o  = rst_n & s_idex;
    assign stall_ex_mem_o = rst_n & s_exmem;
    assign flush_if_id_o  = rst_n & f_ifid;
    assign flush_id_ex_o  = rst_n & f_idex;
    assign halt_o         = rst_n & halt;
    assign fwd_1_sel_o    = rst_n ? fwd_sel[0] : 2'b00;
    assign fwd_2_sel_o    = rst_n ? fwd_sel[1] : 2'b00;
    assign state_o        = rst_n ? state_q : 2'b00;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, load-use/RAW, jump, freeze/pending jump, halt timeout.
module tb_pipe_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid_i;
    logic [4:0] id_rs1_i, id_rs2_i, ex_w_reg_addr_i, mem_w_reg_addr_i, wb_w_reg_addr_i;
    logic       ex_is_load_i, mem_busy_i, ex_jump_i;
    logic       stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o;
    logic       flush_if_id_o, flush_id_ex_o, halt_o;
    logic [1:0] fwd_1_sel_o, fwd_2_sel_o, state_o;

    int n_cmp = 0;
    int n_err = 0;

    // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, halt}
    localparam logic [6:0] NONE = 7'b0000_000;
    localparam logic [6:0] ALLS = 7'b1111_000;
    localparam logic [6:0] LU   = 7'b1100_010;
    localparam logic [6:0] JMP  = 7'b0000_110;
    localparam logic [6:0] HLT  = 7'b1111_001;
    localparam logic [1:0] S_RUN = 2'b00, S_FRZ = 2'b01, S_HLT = 2'b10;

    logic [6:0] outs;
    assign outs = {stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o,
                   flush_if_id_o, flush_id_ex_o, halt_o};

    pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .ex_w_reg_addr_i(ex_w_reg_addr_i), .mem_w_reg_addr_i(mem_w_reg_addr_i),
        .wb_w_reg_addr_i(wb_w_reg_addr_i), .ex_is_load_i(ex_is_load_i),
        .mem_busy_i(mem_busy_i), .ex_jump_i(ex_jump_i),
        .stall_pc_o(stall_pc_o), .stall_if_id_o(stall_if_id_o),
        .stall_id_ex_o(stall_id_ex_o), .stall_ex_mem_o(stall_ex_mem_o),
        .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
        .fwd_1_sel_o(fwd_1_sel_o), .fwd_2_sel_o(fwd_2_sel_o),
        .halt_o(halt_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // inputs change 1 time unit after the edge; checks run 2 units later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid_i = 1'b0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
        ex_w_reg_addr_i = 5'd0; mem_w_reg_addr_i = 5'd0; wb_w_reg_addr_i = 5'd0;
        ex_is_load_i = 1'b0; mem_busy_i = 1'b0; ex_jump_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        // reset holds outputs quiet despite busy, jump and a hazard on the inputs
        id_valid_i = 1'b1; id_rs1_i = 5'd3; ex_w_reg_addr_i = 5'd3; ex_is_load_i = 1'b1;
        mem_busy_i = 1'b1; ex_jump_i = 1'b1; wb_w_reg_addr_i = 5'd3;
        #2;
        check("rst_outs", outs, NONE);
        check("rst_fwd", {fwd_1_sel_o, fwd_2_sel_o}, 4'h0);
        tick(); tick(); #2;
        check("rst_state", state_o, S_RUN);
        check("rst_outs2", outs, NONE);
        tick();
        rst_n = 1'b1;
        idle();
        #2;
        check("idle", outs, NONE);

        // load-use on rs2
        tick();
        id_valid_i = 1'b1; id_rs1_i = 5'd3; id_rs2_i = 5'd5;
        ex_w_reg_addr_i = 5'd5; ex_is_load_i = 1'b1;
        #2;
        check("ldu_outs", outs, LU);
        check("ldu_state", state_o, S_RUN);
        // load moved to MEM
        tick();
        ex_w_reg_addr_i = 5'd9; ex_is_load_i = 1'b0; mem_w_reg_addr_i = 5'd5;
        #2;
`ifdef PIPE_CTRL_FORWARD_EN
        check("mem_fwd_outs", outs, NONE);
        check("mem_fwd2", fwd_2_sel_o, 2'b10);
`else
        check("mem_raw_outs", outs, LU);
        check("mem_fwd2", fwd_2_sel_o, 2'b00);
`endif
        check("mem_fwd1", fwd_1_sel_o, 2'b00);

        // non-load producer in EX on rs1
        tick();
        idle(); id_valid_i = 1'b1; id_rs1_i = 5'd4; ex_w_reg_addr_i = 5'd4;
        #2;
`ifdef PIPE_CTRL_FORWARD_EN
        check("ex_fwd_outs", outs, NONE);
        check("ex_fwd1", fwd_1_sel_o, 2'b01);
`else
        check("ex_raw_outs", outs, LU);
        check("ex_fwd1", fwd_1_sel_o, 2'b00);
`endif

        // WB producer on rs1
        tick();
        idle(); id_valid_i = 1'b1; id_rs1_i = 5'd7; wb_w_reg_addr_i = 5'd7;
        #2;
`ifdef PIPE_CTRL_FORWARD_EN
        check("wb_fwd_outs", outs, NONE);
        check("wb_fwd1", fwd_1_sel_o, 2'b11);
`else
        check("wb_raw_outs", outs, LU);
        check("wb_fwd1", fwd_1_sel_o, 2'b00);
`endif

        // x0 never a hazard
        tick();
        idle(); id_valid_i = 1'b1; ex_is_load_i = 1'b1; wb_w_reg_addr_i = 5'd0;
        #2;
        check("x0_outs", outs, NONE);
        check("x0_fwd", {fwd_1_sel_o, fwd_2_sel_o}, 4'h0);

        // invalid ID slot: no stall
        tick();
        idle(); id_rs2_i = 5'd6; ex_w_reg_addr_i = 5'd6; ex_is_load_i = 1'b1;
        #2;
        check("novalid_outs", outs, NONE);

        // jump beats load-use
        tick();
        id_valid_i = 1'b1; ex_jump_i = 1'b1;
        #2;
        check("jmp_ldu", outs, JMP);
        tick();
        idle();
        #2;
        check("jmp_after", outs, NONE);

        // freeze with a jump deferred across the busy window
        for (int c = 1; c <= 5; c++) begin
            tick();
            idle(); mem_busy_i = 1'b1; ex_jump_i = (c == 3);
            #2;
            check($sformatf("frz_c%0d", c), outs, ALLS);
            check($sformatf("frz_st%0d", c), state_o, (c == 1) ? S_RUN : S_FRZ);
        end
        tick();
        idle(); id_valid_i = 1'b1; id_rs1_i = 5'd2; ex_w_reg_addr_i = 5'd2; ex_is_load_i = 1'b1;
        #2;
        check("pend_flush", outs, JMP);
        check("pend_state", state_o, S_FRZ);
        tick();
        idle();
        #2;
        check("pend_clear", outs, NONE);
        check("pend_run", state_o, S_RUN);

        // reset mid-freeze drops the pending jump
        tick();
        mem_busy_i = 1'b1; ex_jump_i = 1'b1;
        tick();
        ex_jump_i = 1'b0;
        #2;
        check("pre_rst_state", state_o, S_FRZ);
        rst_n = 1'b0;
        #1;
        check("midrst_outs", outs, NONE);
        check("midrst_state", state_o, S_RUN);
        tick();
        rst_n = 1'b1;
        idle();
        #2;
        check("postrst_outs", outs, NONE);
        check("postrst_state", state_o, S_RUN);

        // 255 busy cycles stay in FREEZE
        for (int c = 1; c <= 255; c++) begin
            tick();
            mem_busy_i = 1'b1;
            #2;
            if (c >= 2) check($sformatf("w255_st%0d", c), state_o, S_FRZ);
            check($sformatf("w255_h%0d", c), halt_o, 1'b0);
        end
        tick();
        mem_busy_i = 1'b0;
        #2;
        check("w255_release", outs, NONE);
        tick();
        #2;
        check("w255_run", state_o, S_RUN);

        // 256 busy cycles reach HALT
        for (int c = 1; c <= 256; c++) begin
            tick();
            mem_busy_i = 1'b1;
            #2;
            if (c == 256) check("w256_last", state_o, S_FRZ);
        end
        tick();
        idle(); ex_jump_i = 1'b1;
        #2;
        check("halt_state", state_o, S_HLT);
        check("halt_outs", outs, HLT);
        tick();
        idle(); id_valid_i = 1'b1; id_rs1_i = 5'd3; ex_w_reg_addr_i = 5'd3; ex_is_load_i = 1'b1;
        #2;
        check("halt_hold", outs, HLT);
        check("halt_hold_st", state_o, S_HLT);
        tick();
        rst_n = 1'b0;
        #2;
        check("halt_rst_outs", outs, NONE);
        check("halt_rst_state", state_o, S_RUN);
        tick();
        rst_n = 1'b1;
        idle();
        tick();
        #2;
        check("final_state", state_o, S_RUN);
        check("final_outs", outs, NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1 system clock; rst_n in 1 reset; one clock; reset is asynchronous and active-low.
REQ-002 SHALL have inputs: id_valid_i 1, ID holds a real instruction; id_rs1_i/id_rs2_i 5 each, decoded read addresses, x0 = unused; ex_w_reg_addr_i/mem_w_reg_addr_i/wb_w_reg_addr_i 5 each, stage destination, x0 = none; ex_is_load_i 1; mem_busy_i 1, data access incomplete; ex_jump_i 1, one-cycle pulse on taken branch or jump.
REQ-003 SHALL have outputs: stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o 1 each; flush_if_id_o, flush_id_ex_o 1 each (bubble); fwd_1_sel_o/fwd_2_sel_o 2 each (00 regfile, 01 EX, 10 MEM, 11 WB); halt_o 1; state_o 2.

Function
REQ-004 SHALL implement FSM RUN=00, FREEZE=01, HALT=10, visible on state_o.
REQ-005 Freeze: when mem_busy_i=1 in RUN or FREEZE, SHALL assert all four stalls and deassert both flushes in the same cycle (combinational).
REQ-006 RUN with mem_busy_i=1 SHALL go to FREEZE and load wait_cnt (8 bit) with 1.
REQ-007 FREEZE with mem_busy_i=1 SHALL increment wait_cnt; if wait_cnt==255, SHALL go to HALT instead.
REQ-008 FREEZE with mem_busy_i=0 SHALL return to RUN; outputs that cycle follow RUN rules.
REQ-009 HALT SHALL assert all four stalls and halt_o, deassert flushes, ignore all inputs; exit only by reset.
REQ-010 Jump: ex_jump_i=1 with mem_busy_i=0 (RUN or FREEZE) SHALL assert flush_if_id_o and flush_id_ex_o in the same cycle; stalls 0.
REQ-011 ex_jump_i=1 with mem_busy_i=1 SHALL set jump_pend; jump_pend SHALL act as ex_jump_i in the first cycle with mem_busy_i=0 and then clear.
REQ-012 Load-use: id_valid_i, ex_is_load_i, ex_w_reg_addr_i!=0 and it equals id_rs1_i or id_rs2_i (nonzero) SHALL assert stall_pc_o, stall_if_id_o, flush_id_ex_o in the same cycle.
REQ-013 Priority SHALL be HALT > freeze > jump (incl. pending) > load-use/RAW stall.
REQ-014 Register x0 SHALL never match as a hazard or forward source.

Reset
REQ-015 While rst_n low: state RUN, wait_cnt 0, jump_pend 0; all stall/flush outputs and halt_o 0, fwd selects 00, state_o 00, regardless of inputs.
REQ-016 Reset asserted mid-FREEZE or in HALT SHALL discard the pending jump and the count.

Configuration
REQ-017 Macro PIPE_CTRL_FORWARD_EN defined: per operand, fwd_sel = 01 if matches EX and !ex_is_load_i, else 10 if matches MEM, else 11 if matches WB, else 00; stall only per REQ-012.
REQ-018 Macro undefined: fwd selects fixed 00; any nonzero operand match against EX, MEM or WB destination SHALL apply the REQ-012 stall+bubble.

Verification
REQ-019 RUN, ex_is_load_i=1, ex_w=5, id_rs2=5, id_valid=1 -> same cycle stall_pc=1, stall_if_id=1, flush_id_ex=1; next cycle (load in MEM, mem_w=5) with FORWARD_EN -> no stall, fwd_2_sel=10.
REQ-020 mem_busy_i high 255 cycles then low -> state FREEZE throughout, RUN after, halt_o=0; high 256 cycles -> state_o=10, halt_o=1 from cycle 257 until rst_n low.
REQ-021 FREEZE, ex_jump_i pulse at busy cycle 3, busy drops at cycle 6 -> flushes=1 only in cycle 6 with all stalls 0; cycle 7 flushes=0.
REQ-022 RUN, ex_jump_i=1 with concurrent load-use match -> flush_if_id=1, flush_id_ex=1, stall_pc=0.
REQ-023 Without FORWARD_EN, id_rs1=7, wb_w=7 -> stall_pc=1, flush_id_ex=1, fwd_1_sel=00; id_rs1=0, ex_w=0 -> no stall.
REQ-024 rst_n pulsed low in FREEZE with jump_pend=1 -> after release state RUN, mem_busy_i=0 gives flushes 0.
